rs485_frame_responder: RTL
==========================

Name: rs485_frame_responder

Overview:
Slave-side RS485 node logic. Parses request frames from the byte stream of the UART receiver. For frames addressed to this node, executes the command and returns a reply frame through the UART transmitter. Sits between uart_recv/uart_send and the board LEDs/keys, replacing direct key-to-LED byte passing with an addressed request/response protocol.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 115200, line baud rate; sets byte time BT = CLK_FREQ/UART_BPS*10 cycles
NODE_ADDR, 8'h01, this node's address; 8'hFF is broadcast

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
rx_done  input  1  one-cycle pulse, rx_data valid (from uart_recv uart_done)
rx_data  input  8  received byte
tx_busy  input  1  transmitter busy (from uart_send tx_flag)
tx_en  output  1  one-cycle send request to uart_send uart_en
tx_data  output  8  byte to send; held stable from tx_en until tx_busy falls
key_value  input  4  debounced key state, returned by CMD_RD_KEY
led  output  4  LED register, written by CMD_WR_LED
frame_ok  output  1  one-cycle pulse when a valid addressed/broadcast frame is executed

Behaviour:
- One clock (sys_clk); reset is asynchronous, active-low (sys_rst_n). Reset value of every output is 0. FSM returns to RX_HDR, all counters clear.
- Request frame, 5 bytes: 8'hA5, ADDR, CMD, DATA, CHK. CHK = (ADDR+CMD+DATA) mod 256.
- Reply frame, 5 bytes: 8'h5A, NODE_ADDR, RCMD, RDATA, CHK. CHK = (NODE_ADDR+RCMD+RDATA) mod 256.
- Commands:
  - 8'h01 WR_LED: led <= DATA[3:0]. Reply RCMD=8'h81, RDATA={4'd0,led_new}.
  - 8'h02 RD_LED: reply RCMD=8'h82, RDATA={4'd0,led}.
  - 8'h03 RD_KEY: reply RCMD=8'h83, RDATA={4'd0,key_value} sampled in EXEC.
  - Any other CMD: reply RCMD=8'hEE, RDATA=CMD.
- RX FSM states: RX_HDR -> RX_ADDR -> RX_CMD -> RX_DATA -> RX_CHK -> EXEC -> TURN -> TX_BYTE -> TX_WAIT -> back to RX_HDR.
- In RX_HDR, any byte other than 8'hA5 is discarded. Each later state advances on rx_done.
- Inter-byte timeout: in RX_ADDR..RX_CHK, if no rx_done arrives for 2*BT cycles, go to RX_HDR (partial frame dropped).
- RX_CHK mismatch: drop silently, go to RX_HDR, no frame_ok.
- ADDR not NODE_ADDR and not 8'hFF: frame consumed, no action, go to RX_HDR.
- EXEC lasts exactly one cycle: apply command, pulse frame_ok.
- Broadcast: commands are executed, but no reply is sent; go to RX_HDR.
- TURN: wait BT cycles (bus turnaround), then go to TX_BYTE with index 0.
- TX_BYTE: drive tx_data, pulse tx_en for one cycle, go to TX_WAIT.
- TX_WAIT: wait for tx_busy high, then low. The next byte is issued no earlier than the cycle after tx_busy falls. After byte index 4, go to RX_HDR.
- If tx_busy does not rise within 4 cycles of tx_en, treat the byte as sent.
- rx_done during EXEC/TURN/TX_*: ignored (half-duplex echo suppression).
- led changes only in EXEC. It holds through reset release until written.
- Reset asserted mid-reply: tx_en drops immediately and the reply is abandoned. The line is left idle by uart_send's own reset.

Optional Feature:
RESP_ERR_CNT_EN:
- Defined: an 8-bit saturating counter (stops at 255) increments on each checksum mismatch or inter-byte timeout.
  - CMD 8'h04 replies RCMD=8'h84, RDATA=count.
  - CMD 8'h05 clears it and replies RCMD=8'h85, RDATA=8'h00.
- Undefined: no counter exists; 8'h04 and 8'h05 take the unknown-command path (RCMD=8'hEE).

Decomposition:
- Package rs485_proto_pkg: header bytes A5/5A, broadcast address FF, command codes 01–05, reply codes 81–85/EE, FSM state enum.
- One sub-module, rs485_tx_seq: owns the 5-byte reply shift, index counter, tx_en pulse and tx_busy handshake. It takes start, rcmd, rdata and returns done.
- The parser, timeout counter and command execution stay in the top.

Test Plan:
- A5 01 01 05 07 -> led=4'h5, frame_ok pulse; after BT idle, tx bytes 5A 01 81 05 87.
- A5 01 03 00 04 with key_value=4'hA -> reply 5A 01 83 0A 8E.
- A5 FF 01 0C 0C -> led=4'hC, frame_ok pulse, no tx_en for 10*BT cycles.
- A5 01 01 05 08 (bad CHK) -> led unchanged, no reply. With RESP_ERR_CNT_EN, a following A5 01 04 00 05 replies 5A 01 84 01 86.
- A5 01 then 3*BT gap then A5 02 01 03 06 -> partial frame dropped; address mismatch gives no reply and led unchanged.
- A5 01 07 00 08 -> reply 5A 01 EE 07 F6. Assert sys_rst_n low during reply byte 2 -> tx_en, led, frame_ok all 0 and FSM in RX_HDR.

Source files
------------

// File: rtl/rs485_proto_pkg.sv
// Protocol constants, FSM state types and checksum helper shared by the
// RS485 frame responder and its reply sequencer.
package rs485_proto_pkg;

    localparam logic [7:0] HDR_REQ    = 8'hA5;
    localparam logic [7:0] HDR_RSP    = 8'h5A;
    localparam logic [7:0] ADDR_BCAST = 8'hFF;

    localparam logic [7:0] CMD_WR_LED  = 8'h01;
    localparam logic [7:0] CMD_RD_LED  = 8'h02;
    localparam logic [7:0] CMD_RD_KEY  = 8'h03;
    localparam logic [7:0] CMD_RD_ERR  = 8'h04;
    localparam logic [7:0] CMD_CLR_ERR = 8'h05;

    localparam logic [7:0] RSP_WR_LED  = 8'h81;
    localparam logic [7:0] RSP_RD_LED  = 8'h82;
    localparam logic [7:0] RSP_RD_KEY  = 8'h83;
    localparam logic [7:0] RSP_RD_ERR  = 8'h84;
    localparam logic [7:0] RSP_CLR_ERR = 8'h85;
    localparam logic [7:0] RSP_UNKNOWN = 8'hEE;

    typedef enum logic [3:0] {
        StRxHdr,
        StRxAddr,
        StRxCmd,
        StRxData,
        StRxChk,
        StExec,
        StTurn,
        StTxByte,
        StTxWait
    } rs485_state_e;

    typedef enum logic [1:0] {
        SqIdle,
        SqByte,
        SqWait
    } tx_seq_state_e;

    function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
        return a + b + c;
    endfunction

endpackage

// File: rtl/rs485_tx_seq.sv
// Reply sequencer: shifts a 5-byte reply frame out to uart_send, one byte per
// tx_en pulse, pacing each byte on the transmitter's busy flag.
module rs485_tx_seq
    import rs485_proto_pkg::*;
#(
    parameter logic [7:0] NODE_ADDR = 8'h01
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] rcmd_i,
    input  logic [7:0] rdata_i,
    input  logic       tx_busy_i,
    output logic       tx_en_o,
    output logic [7:0] tx_data_o,
    output logic       done_o
);

    tx_seq_state_e sq_q, sq_d;
    logic [39:0]   shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic          seen_q, seen_d;
    logic          byte_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sq_q    <= SqIdle;
            shift_q <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            seen_q  <= 1'b0;
        end else begin
            sq_q    <= sq_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            seen_q  <= seen_d;
        end
    end

    // Top byte of the shift register stays on the bus until the byte completes.
    assign tx_data_o = shift_q[39:32];

    always_comb begin
        sq_d      = sq_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        seen_d    = seen_q;
        tx_en_o   = 1'b0;
        done_o    = 1'b0;
        byte_done = 1'b0;

        unique case (sq_q)
            SqIdle: begin
                if (start_i) begin
                    shift_d = {HDR_RSP, NODE_ADDR, rcmd_i, rdata_i,
                               frame_chk(NODE_ADDR, rcmd_i, rdata_i)};
                    idx_d   = '0;
                    sq_d    = SqByte;
                end
            end
            SqByte: begin
                tx_en_o = 1'b1;
                wcnt_d  = '0;
                seen_d  = 1'b0;
                sq_d    = SqWait;
            end
            SqWait: begin
                // A transmitter that never raises busy is assumed to have sent the byte.
                if (!seen_q) begin
                    if (tx_busy_i) begin
                        seen_d = 1'b1;
                    end else if (wcnt_q == 2'd3) begin
                        byte_done = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 2'd1;
                    end
                end else if (!tx_busy_i) begin
                    byte_done = 1'b1;
                end

                if (byte_done) begin
                    shift_d = {shift_q[31:0], 8'h00};
                    if (idx_q == 3'd4) begin
                        done_o = 1'b1;
                        sq_d   = SqIdle;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        sq_d  = SqByte;
                    end
                end
            end
            default: sq_d = SqIdle;
        endcase
    end

endmodule

// File: rtl/rs485_frame_responder.sv
// Addressed RS485 slave: parses A5 request frames, executes LED/key commands
// and returns 5A reply frames. RESP_ERR_CNT_EN adds a frame error counter.
module rs485_frame_responder
    import rs485_proto_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned UART_BPS  = 115200,
    parameter logic [7:0]  NODE_ADDR = 8'h01
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic [3:0] key_value,
    output logic [3:0] led,
    output logic       frame_ok
);

    localparam int unsigned BT    = CLK_FREQ / UART_BPS * 10;
    localparam int unsigned TMO   = 2 * BT;
    localparam int unsigned CNT_W = $clog2(TMO + 1);

    rs485_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       led_q, led_d;
    logic [7:0]       rcmd_q, rcmd_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             tx_start;
    logic             tx_done;
`ifdef RESP_ERR_CNT_EN
    logic [7:0]       err_q;
    logic             err_inc;
    logic             err_clr;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StRxHdr;
            cnt_q   <= '0;
            addr_q  <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            led_q   <= '0;
            rcmd_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            led_q   <= led_d;
            rcmd_q  <= rcmd_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef RESP_ERR_CNT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_q <= '0;
        end else if (err_clr) begin
            err_q <= '0;
        end else if (err_inc && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        led_d    = led_q;
        rcmd_d   = rcmd_q;
        rdata_d  = rdata_q;
        tx_start = 1'b0;
`ifdef RESP_ERR_CNT_EN
        err_inc  = 1'b0;
        err_clr  = 1'b0;
`endif

        case (state_q)
            StRxHdr: begin
                cnt_d = '0;
                if (rx_done && rx_data == HDR_REQ) begin
                    state_d = StRxAddr;
                end
            end
            StRxAddr, StRxCmd, StRxData, StRxChk: begin
                if (rx_done) begin
                    cnt_d = '0;
                    case (state_q)
                        StRxAddr: begin
                            addr_d  = rx_data;
                            state_d = StRxCmd;
                        end
                        StRxCmd: begin
                            cmd_d   = rx_data;
                            state_d = StRxData;
                        end
                        StRxData: begin
                            data_d  = rx_data;
                            state_d = StRxChk;
                        end
                        default: begin
                            if (rx_data != frame_chk(addr_q, cmd_q, data_q)) begin
                                state_d = StRxHdr;
`ifdef RESP_ERR_CNT_EN
                                err_inc = 1'b1;
`endif
                            end else if (addr_q == NODE_ADDR || addr_q == ADDR_BCAST) begin
                                state_d = StExec;
                            end else begin
                                state_d = StRxHdr;
                            end
                        end
                    endcase
                end else if (cnt_q == CNT_W'(TMO - 1)) begin
                    // Line went quiet mid-frame: drop the partial frame.
                    cnt_d   = '0;
                    state_d = StRxHdr;
`ifdef RESP_ERR_CNT_EN
                    err_inc = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StExec: begin
                case (cmd_q)
                    CMD_WR_LED: begin
                        led_d   = data_q[3:0];
                        rcmd_d  = RSP_WR_LED;
                        rdata_d = {4'd0, data_q[3:0]};
                    end
                    CMD_RD_LED: begin
                        rcmd_d  = RSP_RD_LED;
                        rdata_d = {4'd0, led_q};
                    end
                    CMD_RD_KEY: begin
                        rcmd_d  = RSP_RD_KEY;
                        rdata_d = {4'd0, key_value};
                    end
`ifdef RESP_ERR_CNT_EN
                    CMD_RD_ERR: begin
                        rcmd_d  = RSP_RD_ERR;
                        rdata_d = err_q;
                    end
                    CMD_CLR_ERR: begin
                        err_clr = 1'b1;
                        rcmd_d  = RSP_CLR_ERR;
                        rdata_d = 8'h00;
                    end
`endif
                    default: begin
                        rcmd_d  = RSP_UNKNOWN;
                        rdata_d = cmd_q;
                    end
                endcase
                cnt_d   = '0;
                state_d = (addr_q == ADDR_BCAST) ? StRxHdr : StTurn;
            end
            StTurn: begin
                if (cnt_q == CNT_W'(BT - 1)) begin
                    cnt_d   = '0;
                    state_d = StTxByte;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTxByte: begin
                tx_start = 1'b1;
                state_d  = StTxWait;
            end
            StTxWait: begin
                if (tx_done) begin
                    state_d = StRxHdr;
                end
            end
            default: state_d = StRxHdr;
        endcase
    end

    assign led      = led_q;
    assign frame_ok = (state_q == StExec);

    rs485_tx_seq #(
        .NODE_ADDR (NODE_ADDR)
    ) u_tx_seq (
        .clk_i     (sys_clk),
        .rst_ni    (sys_rst_n),
        .start_i   (tx_start),
        .rcmd_i    (rcmd_q),
        .rdata_i   (rdata_q),
        .tx_busy_i (tx_busy),
        .tx_en_o   (tx_en),
        .tx_data_o (tx_data),
        .done_o    (tx_done)
    );

endmodule
